// File: rtl/lc3_prog_loader.sv
// LC3 program loader: accepts a big-endian object image byte stream, writes it into
// LC3 memory one word at a time, then releases the core (or holds it in reset on a bad image).
`ifndef MEMORY_WORDCOUNT
`define MEMORY_WORDCOUNT 65536
`endif

module lc3_prog_loader #(
  parameter int unsigned MEMORY_WORDCOUNT = `MEMORY_WORDCOUNT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_ORIG_HI = 4'd0,
    S_ORIG_LO = 4'd1,
    S_CNT_HI  = 4'd2,
    S_CNT_LO  = 4'd3,
    S_DATA_HI = 4'd4,
    S_DATA_LO = 4'd5,
    S_WRITE   = 4'd6,
    S_RUN     = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam logic [16:0] LP_WORDS = 17'(MEMORY_WORDCOUNT);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_orig;
  logic [15:0] r_cnt;
  logic [15:0] r_idx;
  logic [7:0]  r_hi;
  logic        r_in_ready;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_cpu_reset_n;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic        w_next_ready;
  logic [15:0] w_cnt_full;
  logic [16:0] w_end;
  logic [15:0] w_idx_next;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_cnt_full = {r_cnt[15:8], in_data};
  // 17-bit sum so an image running past the top of a full 64K memory is still caught
  assign w_end      = {1'b0, r_orig} + {1'b0, w_cnt_full};
  assign w_idx_next = r_idx + 16'd1;

  // Next-state decode for the load sequence
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ORIG_HI: begin
        if (w_xfer) w_next_state = S_ORIG_LO;
        else        w_next_state = r_state;
      end
      S_ORIG_LO: begin
        if (w_xfer) w_next_state = S_CNT_HI;
        else        w_next_state = r_state;
      end
      S_CNT_HI: begin
        if (w_xfer) w_next_state = S_CNT_LO;
        else        w_next_state = r_state;
      end
      S_CNT_LO: begin
        if (w_xfer) begin
          if (w_cnt_full == 16'd0)     w_next_state = S_RUN;
          else if (w_end > LP_WORDS)   w_next_state = S_ERR;
          else                         w_next_state = S_DATA_HI;
        end else begin
          w_next_state = r_state;
        end
      end
      S_DATA_HI: begin
        if (w_xfer) w_next_state = S_DATA_LO;
        else        w_next_state = r_state;
      end
      S_DATA_LO: begin
        if (w_xfer) w_next_state = S_WRITE;
        else        w_next_state = r_state;
      end
      S_WRITE: begin
        if (w_idx_next == r_cnt) w_next_state = S_RUN;
        else                     w_next_state = S_DATA_HI;
      end
      S_RUN:   w_next_state = S_RUN;
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_ERR;
    endcase
  end

  // Ready is asserted only in the byte-accepting states
  always_comb begin
    w_next_ready = 1'b0;
    if (w_next_state inside {S_ORIG_HI, S_ORIG_LO, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO}) begin
      w_next_ready = 1'b1;
    end else begin
      w_next_ready = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_ORIG_HI;
    else          r_state <= w_next_state;
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cpu_reset_n <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_in_ready    <= w_next_ready;
      r_mem_we      <= (w_next_state == S_WRITE);
      r_cpu_reset_n <= (w_next_state == S_RUN);
      r_done        <= (w_next_state == S_RUN);
      r_error       <= (w_next_state == S_ERR);
    end
  end

  // Header capture, word assembly and write-address generation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_orig      <= 16'd0;
      r_cnt       <= 16'd0;
      r_idx       <= 16'd0;
      r_hi        <= 8'd0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 16'd0;
    end else begin
      if (w_xfer) begin
        case (r_state)
          S_ORIG_HI: r_orig[15:8] <= in_data;
          S_ORIG_LO: r_orig[7:0]  <= in_data;
          S_CNT_HI:  r_cnt[15:8]  <= in_data;
          S_CNT_LO:  r_cnt[7:0]   <= in_data;
          S_DATA_HI: r_hi         <= in_data;
          S_DATA_LO: begin
            r_mem_wdata <= {r_hi, in_data};
            r_mem_addr  <= r_orig + r_idx;
          end
          default: r_hi <= r_hi;
        endcase
      end
      if (r_state == S_WRITE) r_idx <= w_idx_next;
    end
  end

  assign in_ready    = r_in_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign cpu_reset_n = r_cpu_reset_n;
  assign done        = r_done;
  assign error       = r_error;

endmodule
